assoc_ram: RTL and testbench
============================

# assoc_ram

Parametrised associative (sparse) synchronous memory that stores up to ENTRIES address/data pairs and serves the CPU testbench data path as a sparse data memory. Writes to a stored address update it; writes to a new address allocate a free entry. Adds byte enables, a configurable read latency with a valid strobe, hit/full/error status and an occupancy counter. Replaces the earlier fixed-size, file-initialised lookup memory for bench and cache-model use.

## Interface
- AW, 32: address width in bits.
- DW, 32: data width in bits; must be a multiple of 8.
- ENTRIES, 16: number of address/data slots; power of two, 2..256.
- RD_LAT, 1: read latency in cycles; legal values 1 or 2.
- MISS_DATA, 0: DW-bit value returned on a read miss.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- cs  input  1  chip select; oe, we and clr are ignored when low.
- oe  input  1  read request.
- we  input  1  write request.
- clr  input  1  invalidate all entries (requires cs).
- be  input  DW/8  byte enables for writes; bit i covers din[8i+7:8i].
- addr  input  AW  access address (full-width tag, no alignment assumed).
- din  input  DW  write data.
- dout  output  DW  read data, held until the next rvalid.
- rvalid  output  1  one-cycle strobe: dout/hit are new.
- hit  output  1  read at the rvalid strobe matched a stored entry.
- full  output  1  all ENTRIES slots valid.
- count  output  $clog2(ENTRIES)+1  number of valid entries.
- err  output  1  one-cycle pulse: write miss dropped because the memory was full.

## Operation
- Storage per slot: valid bit, AW-bit tag, DW-bit data. Reset clears all valid bits; tag and data are not reset.
- Lookup: compare addr against all valid tags. At most one slot matches (the allocation rule guarantees no duplicates).
- Read (cs & oe): capture the lookup result, either the matching data or MISS_DATA, plus the hit flag, into the read pipeline.
- Write hit (cs & we, match): merge per byte; bytes with be=1 take din, all others keep their old value. count unchanged.
- Write miss, not full: allocate the lowest-indexed invalid slot. Tag = addr; data = din with unenabled bytes forced to 0; count +1.
- Write miss, full: no state change; err=1 on the next cycle.
- be=0 on a write hit: no data change, but the write still counts as a hit. be=0 on a write miss still allocates a slot with data 0.
- Read and write in the same cycle: the read samples pre-write contents (read-old-data). The write follows the normal rules.
- clr (cs & clr): all valid bits are cleared at the clock edge and count goes to 0.
  - A read in the same cycle still samples pre-clear contents.
  - A write in the same cycle is discarded; clr has priority.
- cs low: no state change; rvalid, err pulses still drain from the pipeline.

## Timing
- Reset values: dout=0, rvalid=0, hit=0, full=0, count=0, err=0. Pipeline stages are cleared.
- Reset mid-read: in-flight reads are lost and no rvalid is produced for them.
- RD_LAT=1: read issued at edge N gives dout/hit/rvalid registered at edge N+1.
- RD_LAT=2: an extra register stage gives results at edge N+2. Back-to-back reads give one rvalid per cycle with no bubbles.
- dout and hit change only on cycles where rvalid=1.
- count and full update at the same edge as the write or clr. A write on cycle N is visible to a read issued on cycle N+1.
- err is registered: write miss when full at edge N gives err=1 during cycle N+1 only.

## Test plan
- Reset, ENTRIES=4, RD_LAT=1: write 0x100←0xDEADBEEF (be=0xF), then read 0x100 → next cycle dout=0xDEADBEEF, hit=1, rvalid=1, count=1.
- Byte merge: over 0x100=0xDEADBEEF, write din=0x11223344 with be=0x5 → read returns 0xDE22BE44. A write with be=0x1 to new address 0x200 with din=0xAABBCCDD → stores 0x000000DD.
- Fill and overflow with ENTRIES=4: write 4 distinct addresses → full=1, count=4. A 5th new address → err pulse for one cycle, count stays 4, read of the 5th address gives hit=0, dout=MISS_DATA. Rewrite an existing address → no err.
- Same-cycle read+write to 0x100 (old 0x1, new 0x2) → rvalid data 0x1. Read 0x100 on the following cycle → 0x2.
- RD_LAT=2: reads of A, B, C on consecutive cycles → rvalid high on three consecutive cycles starting 2 cycles after A, data in order A, B, C. Assert rst_n=0 during the cycle after the B issue → no further rvalid, all outputs 0.
- clr with count=3, plus a simultaneous write to a new address → count=0, full=0, and a later read of that address misses.

Source files
------------

// File: rtl/assoc_ram.sv
// Sparse associative memory: up to ENTRIES address/data pairs with byte-enabled writes,
// fixed read latency (1 or 2) with a valid strobe, and hit/full/err/occupancy status.
module assoc_ram #(
  parameter int unsigned    AW        = 32,
  parameter int unsigned    DW        = 32,
  parameter int unsigned    ENTRIES   = 16,
  parameter int unsigned    RD_LAT    = 1,
  parameter logic [DW-1:0]  MISS_DATA = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cs,
  input  logic                         oe,
  input  logic                         we,
  input  logic                         clr,
  input  logic [DW/8-1:0]              be,
  input  logic [AW-1:0]                addr,
  input  logic [DW-1:0]                din,
  output logic [DW-1:0]                dout,
  output logic                         rvalid,
  output logic                         hit,
  output logic                         full,
  output logic [$clog2(ENTRIES):0]     count,
  output logic                         err
);

  localparam int unsigned IW = $clog2(ENTRIES);
  localparam int unsigned CW = IW + 1;
  localparam int unsigned BW = DW / 8;

  logic [ENTRIES-1:0] valid_q;
  logic [AW-1:0]      tag_q  [ENTRIES];
  logic [DW-1:0]      data_q [ENTRIES];
  logic [CW-1:0]      count_q;
  logic               err_q;

  logic               hit_any;
  logic [IW-1:0]      hit_idx;
  logic [IW-1:0]      free_idx;
  logic [DW-1:0]      wmask;
  logic [DW-1:0]      rd_data;
  logic               rd_req, do_clr, do_wr, wr_hit, wr_alloc, wr_drop;

  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (valid_q[i] && (tag_q[i] == addr)) begin
        hit_any = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  // Descending scan so the lowest-indexed free slot wins.
  always_comb begin
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) free_idx = IW'(i);
    end
  end

  always_comb begin
    wmask = '0;
    for (int b = 0; b < BW; b++) wmask[8*b +: 8] = {8{be[b]}};
  end

  assign full     = (count_q == CW'(ENTRIES));
  assign rd_req   = cs & oe;
  assign do_clr   = cs & clr;
  assign do_wr    = cs & we & ~clr;
  assign wr_hit   = do_wr & hit_any;
  assign wr_alloc = do_wr & ~hit_any & ~full;
  assign wr_drop  = do_wr & ~hit_any & full;
  assign rd_data  = hit_any ? data_q[hit_idx] : MISS_DATA;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= wr_drop;
      if (do_clr) begin
        valid_q <= '0;
        count_q <= '0;
      end else if (wr_alloc) begin
        valid_q[free_idx] <= 1'b1;
        count_q           <= count_q + CW'(1);
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (wr_hit) begin
      data_q[hit_idx] <= (din & wmask) | (data_q[hit_idx] & ~wmask);
    end else if (wr_alloc) begin
      tag_q[free_idx]  <= addr;
      data_q[free_idx] <= din & wmask;
    end
  end

  logic          pipe_vld;
  logic          pipe_hit;
  logic [DW-1:0] pipe_data;

  if (RD_LAT == 2) begin : g_lat2
    logic          s1_vld_q;
    logic          s1_hit_q;
    logic [DW-1:0] s1_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_vld_q  <= 1'b0;
        s1_hit_q  <= 1'b0;
        s1_data_q <= '0;
      end else begin
        s1_vld_q <= rd_req;
        if (rd_req) begin
          s1_hit_q  <= hit_any;
          s1_data_q <= rd_data;
        end
      end
    end

    assign pipe_vld  = s1_vld_q;
    assign pipe_hit  = s1_hit_q;
    assign pipe_data = s1_data_q;
  end else begin : g_lat1
    assign pipe_vld  = rd_req;
    assign pipe_hit  = hit_any;
    assign pipe_data = rd_data;
  end

  logic          rvalid_q;
  logic          hit_q;
  logic [DW-1:0] dout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      hit_q    <= 1'b0;
      dout_q   <= '0;
    end else begin
      rvalid_q <= pipe_vld;
      if (pipe_vld) begin
        hit_q  <= pipe_hit;
        dout_q <= pipe_data;
      end
    end
  end

  assign rvalid = rvalid_q;
  assign hit    = hit_q;
  assign dout   = dout_q;
  assign count  = count_q;
  assign err    = err_q;

endmodule

// File: tb/tb_assoc_ram.sv
// Scoreboard bench for assoc_ram: two instances (read latency 1 and 2) share stimulus;
// a negedge monitor pops expected read responses including their arrival cycle.
module tb_assoc_ram;

  localparam logic [31:0] MISS = 32'hBAD0_BAD0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cs = 1'b0, oe = 1'b0, we = 1'b0, clr = 1'b0;
  logic [3:0]  be = '0;
  logic [31:0] addr = '0, din = '0;

  logic [31:0] dout1, dout2;
  logic        rvalid1, rvalid2, hit1, hit2, full1, full2, err1, err2;
  logic [2:0]  count1, count2;

  typedef struct {
    logic [31:0] data;
    logic        hit;
    int          cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  assoc_ram #(.AW(32), .DW(32), .ENTRIES(4), .RD_LAT(1), .MISS_DATA(MISS)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .oe(oe), .we(we), .clr(clr), .be(be), .addr(addr),
    .din(din), .dout(dout1), .rvalid(rvalid1), .hit(hit1), .full(full1), .count(count1),
    .err(err1)
  );

  assoc_ram #(.AW(32), .DW(32), .ENTRIES(4), .RD_LAT(2), .MISS_DATA(MISS)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .cs(cs), .oe(oe), .we(we), .clr(clr), .be(be), .addr(addr),
    .din(din), .dout(dout2), .rvalid(rvalid2), .hit(hit2), .full(full2), .count(count2),
    .err(err2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic pop_cmp(input int k, input logic [31:0] d, input logic h);
    exp_t e;
    n_cmp++;
    if ((k == 1) ? (q1.size() == 0) : (q2.size() == 0)) begin
      n_bad++;
      $display("FAIL rvalid_lat%0d: unexpected strobe dout=%h at cycle %0d, required none", k, d,
               cyc);
      return;
    end
    e = (k == 1) ? q1.pop_front() : q2.pop_front();
    if (d !== e.data || h !== e.hit || cyc != e.cyc) begin
      n_bad++;
      $display("FAIL read_lat%0d: got dout=%h hit=%b cycle=%0d, required dout=%h hit=%b cycle=%0d",
               k, d, h, cyc, e.data, e.hit, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rvalid1) pop_cmp(1, dout1, hit1);
    if (rvalid2) pop_cmp(2, dout2, hit2);
  end

  task automatic status(input string nm, input int c, input logic f, input logic e);
    chk({nm, " count1"}, 32'(count1), 32'(c));
    chk({nm, " count2"}, 32'(count2), 32'(c));
    chk({nm, " full1"}, 32'(full1), 32'(f));
    chk({nm, " full2"}, 32'(full2), 32'(f));
    chk({nm, " err1"}, 32'(err1), 32'(e));
    chk({nm, " err2"}, 32'(err2), 32'(e));
  endtask

  // One access cycle; a read pushes its expected response for both latencies.
  task automatic op(input logic o, input logic w, input logic c, input logic [3:0] b,
                    input logic [31:0] a, input logic [31:0] d,
                    input logic [31:0] e_d, input logic e_h);
    exp_t e;
    cs = 1'b1; oe = o; we = w; clr = c; be = b; addr = a; din = d;
    if (o) begin
      e.data = e_d; e.hit = e_h;
      e.cyc = cyc + 1; q1.push_back(e);
      e.cyc = cyc + 2; q2.push_back(e);
    end
    @(posedge clk);
    #1;
    cs = 1'b0; oe = 1'b0; we = 1'b0; clr = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    op(1'b0, 1'b1, 1'b0, b, a, d, '0, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e_d, input logic e_h);
    op(1'b1, 1'b0, 1'b0, 4'h0, a, '0, e_d, e_h);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic zero_outs(input string nm);
    chk({nm, " dout1"}, dout1, 32'h0);
    chk({nm, " dout2"}, dout2, 32'h0);
    chk({nm, " rvalid"}, {30'h0, rvalid1, rvalid2}, 32'h0);
    chk({nm, " hit"}, {30'h0, hit1, hit2}, 32'h0);
    status(nm, 0, 1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(2);
    zero_outs("reset");
    rst_n = 1'b1;
    idle(1);

    wr(32'h100, 32'hDEAD_BEEF, 4'hF);
    status("first write", 1, 1'b0, 1'b0);
    rd(32'h100, 32'hDEAD_BEEF, 1'b1);

    wr(32'h100, 32'h1122_3344, 4'h5);
    rd(32'h100, 32'hDE22_BE44, 1'b1);
    wr(32'h200, 32'hAABB_CCDD, 4'h1);
    status("alloc partial", 2, 1'b0, 1'b0);
    rd(32'h200, 32'h0000_00DD, 1'b1);

    wr(32'h300, 32'h3333_3333, 4'hF);
    wr(32'h400, 32'h4444_4444, 4'hF);
    status("filled", 4, 1'b1, 1'b0);
    wr(32'h500, 32'h5555_5555, 4'hF);
    status("overflow", 4, 1'b1, 1'b1);
    idle(1);
    status("err one cycle", 4, 1'b1, 1'b0);
    rd(32'h500, MISS, 1'b0);
    wr(32'h300, 32'h0000_0003, 4'hF);
    status("rewrite when full", 4, 1'b1, 1'b0);

    wr(32'h100, 32'h0000_0001, 4'hF);
    op(1'b1, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0000_0002, 32'h0000_0001, 1'b1);
    rd(32'h100, 32'h0000_0002, 1'b1);

    wr(32'h400, 32'hFFFF_FFFF, 4'h0);
    status("be0 hit", 4, 1'b1, 1'b0);
    rd(32'h200, 32'h0000_00DD, 1'b1);
    rd(32'h300, 32'h0000_0003, 1'b1);
    rd(32'h400, 32'h4444_4444, 1'b1);

    op(1'b1, 1'b0, 1'b1, 4'h0, 32'h200, '0, 32'h0000_00DD, 1'b1);
    status("clr", 0, 1'b0, 1'b0);
    wr(32'h10, 32'hA, 4'hF);
    wr(32'h20, 32'hB, 4'hF);
    wr(32'h30, 32'hC, 4'hF);
    status("refill three", 3, 1'b0, 1'b0);
    op(1'b0, 1'b1, 1'b1, 4'hF, 32'h700, 32'h7, '0, 1'b0);
    status("clr beats write", 0, 1'b0, 1'b0);
    rd(32'h700, MISS, 1'b0);
    rd(32'h10, MISS, 1'b0);

    wr(32'h10, 32'hA, 4'hF);
    wr(32'h20, 32'hB, 4'hF);
    wr(32'h30, 32'hC, 4'hF);
    idle(3);
    rd(32'h10, 32'hA, 1'b1);
    rd(32'h20, 32'hB, 1'b1);
    cs = 1'b1; oe = 1'b1; addr = 32'h30;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    cs = 1'b0; oe = 1'b0;
    chk("lat1 drained before reset", q1.size(), 32'd0);
    chk("lat2 in flight at reset", q2.size(), 32'd1);
    q1.delete();
    q2.delete();
    zero_outs("mid-read reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(4);
    zero_outs("after reset");

    wr(32'h40, 32'hFFFF_FFFF, 4'h0);
    status("be0 alloc", 1, 1'b0, 1'b0);
    rd(32'h40, 32'h0, 1'b1);
    rd(32'h10, MISS, 1'b0);

    idle(5);
    chk("lat1 queue drained", q1.size(), 32'd0);
    chk("lat2 queue drained", q2.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
